// File: rtl/linear_weight_loader_if.sv
// Weight-stream bus into the loader and the PE weight-write bus out of it.
// The loader takes the slave view. The stream source (or a bench) takes the master view.
interface linear_weight_loader_if #(
  parameter int unsigned DATA_W = 64
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              load_weight;
  logic [31:0]       weight_addr;
  logic [DATA_W-1:0] weight_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, load_weight, weight_addr, weight_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, load_weight, weight_addr, weight_data
  );
endinterface

// File: rtl/linear_weight_loader.sv
// Preloads the weight and bias image of one linear-layer PE from a valid/ready word stream.
// The PE enable stays gated until the complete image has been written.
module linear_weight_loader #(
  parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned pWEIGHT_WORDS      = 401408,
  parameter int unsigned pBIAS_WORDS        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  linear_weight_loader_if.slave  bus,
  input  logic                   up_valid,
  input  logic                   pe_ready_in,
  output logic                   pe_en,
  output logic                   loaded,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned TOTAL = pWEIGHT_WORDS + pBIAS_WORDS;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_W   = CNT_W'(pWEIGHT_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_ALL = CNT_W'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, READY, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hs;
  logic             final_word;

  assign hs         = bus.s_valid & bus.s_ready;
  assign final_word = (cnt == LAST_ALL);
  assign pe_en      = loaded & up_valid & pe_ready_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.s_ready     <= 1'b0;
      bus.load_weight <= 1'b0;
      bus.weight_addr <= '0;
      bus.weight_data <= '0;
      loaded          <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
    end else begin
      bus.load_weight <= 1'b0;
      case (state)
        IDLE, READY, ERR: begin
          if (start) begin
            state       <= LOAD_W;
            cnt         <= '0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
            loaded      <= 1'b0;
            err         <= 1'b0;
          end
        end
        LOAD_W, LOAD_B: begin
          if (hs) begin
            // Every accepted word is written, including the one that breaks framing.
            bus.load_weight <= 1'b1;
            bus.weight_addr <= pWEIGHT_BASE_ADDR + 32'(cnt);
            bus.weight_data <= pWEIGHT_DATA_WIDTH'(bus.s_data);
            cnt             <= cnt + 1'b1;
            if (final_word && bus.s_last) begin
              state       <= READY;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              loaded      <= 1'b1;
            end else if (final_word || bus.s_last) begin
              state       <= ERR;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              loaded      <= 1'b0;
              err         <= 1'b1;
            end else if (state == LOAD_W && cnt == LAST_W) begin
              state <= LOAD_B;
            end
          end
        end
        default: begin
          state       <= IDLE;
          bus.s_ready <= 1'b0;
          busy        <= 1'b0;
          loaded      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_linear_weight_loader.sv
// Randomized scoreboard bench for linear_weight_loader with a small 8+2 word image.
module tb_linear_weight_loader;
  localparam int          DW   = 64;
  localparam int          NW   = 8;
  localparam int          NB   = 2;
  localparam int          TOT  = NW + NB;
  localparam logic [31:0] BASE = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic up_valid = 1'b0;
  logic pe_ready_in = 1'b0;
  logic pe_en, loaded, busy, err;
  bit   rand_pe = 1'b1;

  linear_weight_loader_if #(.DATA_W(DW)) bus ();

  linear_weight_loader #(
    .pWEIGHT_DATA_WIDTH (DW),
    .pWEIGHT_BASE_ADDR  (BASE),
    .pWEIGHT_WORDS      (NW),
    .pBIAS_WORDS        (NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .up_valid    (up_valid),
    .pe_ready_in (pe_ready_in),
    .pe_en       (pe_en),
    .loaded      (loaded),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mphase_t;

  wr_t           exp_q[$];
  mphase_t       ph = M_IDLE;
  int            idx = 0;
  logic [31:0]   hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  int            n_chk = 0;
  int            n_pass = 0;

  // Reference model: a load accepts words while in progress; the image is good only
  // when exactly TOT words arrive and s_last marks the last of them.
  always @(posedge clk) begin
    if (!rst) begin
      ph        = M_IDLE;
      idx       = 0;
      hold_addr = '0;
      hold_data = '0;
      exp_q.delete();
    end else if (ph == M_LOAD) begin
      if (bus.s_valid) begin
        hold_addr = BASE + 32'(idx);
        hold_data = bus.s_data;
        exp_q.push_back('{addr: hold_addr, data: hold_data});
        if (idx == TOT - 1) ph = bus.s_last ? M_DONE : M_ERR;
        else if (bus.s_last) ph = M_ERR;
        idx++;
      end
    end else if (start) begin
      ph  = M_LOAD;
      idx = 0;
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each PE write.
  always @(negedge clk) begin
    wr_t w;
    chk("s_ready", DW'(bus.s_ready), DW'(ph == M_LOAD));
    chk("busy", DW'(busy), DW'(ph == M_LOAD));
    chk("loaded", DW'(loaded), DW'(ph == M_DONE));
    chk("err", DW'(err), DW'(ph == M_ERR));
    chk("pe_en", DW'(pe_en), DW'((ph == M_DONE) && up_valid && pe_ready_in));
    if (bus.load_weight === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got load_weight=1 addr %h expected no write", bus.weight_addr);
      end else begin
        w = exp_q.pop_front();
        chk("write_addr", DW'(bus.weight_addr), DW'(w.addr));
        chk("write_data", bus.weight_data, w.data);
      end
    end else begin
      chk("load_weight", DW'(bus.load_weight), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    chk("hold_addr", DW'(bus.weight_addr), DW'(hold_addr));
    chk("hold_data", bus.weight_data, hold_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_pe) begin
      up_valid    = 1'($urandom);
      pe_ready_in = 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends n words; s_last on index last_at, optional gaps, optional start on index start_at.
  task automatic send(input int n, input int last_at, input int gap_pct, input bit alt,
                      input bit seq, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (alt || ($urandom_range(99) < gap_pct))) begin
        bus.s_valid = 1'b0;
        tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = seq ? (64'hA0 + 64'(i)) : {$urandom, $urandom};
      bus.s_last  = (i == last_at);
      start       = (i == start_at);
      tick();
      start = 1'b0;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    idle(3);
    rst = 1'b1;
    tick();

    // Back-to-back image, then an image with a gap between every word.
    pulse_start();
    send(TOT, TOT - 1, 0, 1'b0, 1'b1, -1);
    idle(3);
    pulse_start();
    send(TOT, TOT - 1, 0, 1'b1, 1'b1, -1);
    idle(3);

    // Early s_last, words offered while in error, then a clean reload.
    pulse_start();
    send(5, 4, 0, 1'b0, 1'b1, -1);
    send(2, -1, 0, 1'b0, 1'b0, -1);
    idle(2);
    pulse_start();
    send(TOT, TOT - 1, 0, 1'b0, 1'b1, -1);
    idle(2);

    // PE enable gating in READY and while loading.
    rand_pe = 1'b0;
    for (int c = 0; c < 4; c++) begin
      up_valid    = c[1];
      pe_ready_in = c[0];
      tick();
    end
    pulse_start();
    for (int c = 0; c < 4; c++) begin
      up_valid    = c[1];
      pe_ready_in = c[0];
      tick();
    end
    rand_pe = 1'b1;
    send(TOT, TOT - 1, 30, 1'b0, 1'b0, -1);
    idle(2);

    // Reset in the middle of a load, then a full reload.
    pulse_start();
    send(4, -1, 0, 1'b0, 1'b1, -1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    tick();
    pulse_start();
    send(TOT, TOT - 1, 0, 1'b0, 1'b1, -1);
    idle(2);

    // Ignored start mid-load, then a final word without s_last.
    pulse_start();
    send(TOT, TOT - 1, 0, 1'b0, 1'b1, 3);
    idle(2);
    pulse_start();
    send(TOT, -1, 0, 1'b0, 1'b0, -1);
    idle(2);

    // Random images with occasional framing faults and gaps.
    for (int k = 0; k < 25; k++) begin
      int last_at;
      last_at = ($urandom_range(3) == 0) ? int'($urandom_range(TOT - 1)) : TOT - 1;
      pulse_start();
      send(TOT, last_at, 25, 1'b0, 1'b0, int'($urandom_range(15)));
      idle(int'($urandom_range(3)));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
